proc_ctrl_fsm: RTL and testbench

Control unit for the 9-bit-instruction processor datapath. Sequences instruction fetch into the instruction register and execution over time steps T0–T3. Drives the register-file write enables, the bus multiplexer selects, the A/G accumulator loads and the ALU operation. Sits between the external `Run`/`Done` handshake and the datapath register/bus/ALU blocks.

---
 rtl/proc_ctrl_pkg.sv | 47 ++++
 rtl/proc_ctrl_fsm_dec3to8.sv | 18 +
 rtl/proc_ctrl_fsm.sv | 115 +++++++++++
 tb/tb_proc_ctrl_fsm.sv | 133 +++++++++++++
 4 files changed

// File: rtl/proc_ctrl_pkg.sv
// Shared constants for the processor control unit: states, opcodes, ALU codes.
// PROC_CTRL_LOGIC_OPS_EN routes opcodes 100/101 (and/or) down the ALU path.
package proc_ctrl_pkg;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // True for opcodes that take the three-step A/G accumulator path
  function automatic logic is_alu_op(input logic [2:0] op);
    case (op)
      OP_ADD, OP_SUB: return 1'b1;
`ifdef PROC_CTRL_LOGIC_OPS_EN
      OP_AND, OP_OR:  return 1'b1;
`endif
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] alu_code(input logic [2:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
`ifdef PROC_CTRL_LOGIC_OPS_EN
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
`endif
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/proc_ctrl_fsm_dec3to8.sv
// 3-bit to one-hot 8-bit decoder with enable; output all-zero when disabled.
module dec3to8 (
  input  logic       en,
  input  logic [2:0] w,
  output logic [7:0] y
);

  // One-hot decode of w, gated by en
  always_comb begin
    y = 8'h00;
    if (en) begin
      y = 8'h01 << w;
    end else begin
      y = 8'h00;
    end
  end

endmodule

// File: rtl/proc_ctrl_fsm.sv
// Control FSM (T0..T3) for the 9-bit-instruction processor datapath.
// PROC_CTRL_LOGIC_OPS_EN enables the and/or opcodes on the ALU path.
module proc_ctrl_fsm
  import proc_ctrl_pkg::*;
#(
  parameter int NREGS = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Run,
  input  logic [8:0]       IR,
  output logic             IRin,
  output logic [NREGS-1:0] Rin,
  output logic [NREGS-1:0] Rout,
  output logic             DINout,
  output logic             Gout,
  output logic             Ain,
  output logic             Gin,
  output logic [1:0]       ALUop,
  output logic             Done,
  output logic [1:0]       Tstep
);

  state_t           state_r;
  state_t           state_next_s;
  logic [2:0]       opcode_s;
  logic [NREGS-1:0] x_dec_s;
  logic [NREGS-1:0] y_dec_s;

  assign opcode_s = IR[8:6];

  dec3to8 u_dec_x (.en(Resetn), .w(IR[5:3]), .y(x_dec_s));
  dec3to8 u_dec_y (.en(Resetn), .w(IR[2:0]), .y(y_dec_s));

  // State register, synchronous active-low reset
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_r <= T0;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and datapath controls; everything held low during reset
  always_comb begin
    IRin         = 1'b0;
    Rin          = '0;
    Rout         = '0;
    DINout       = 1'b0;
    Gout         = 1'b0;
    Ain          = 1'b0;
    Gin          = 1'b0;
    ALUop        = 2'b00;
    Done         = 1'b0;
    Tstep        = 2'd0;
    state_next_s = state_r;
    if (!Resetn) begin
      state_next_s = T0;
    end else begin
      Tstep = state_r;
      case (state_r)
        T0: begin
          IRin = Run;
          if (Run) begin
            state_next_s = T1;
          end else begin
            state_next_s = T0;
          end
        end
        T1: begin
          if (is_alu_op(opcode_s)) begin
            Rout         = x_dec_s;
            Ain          = 1'b1;
            state_next_s = T2;
          end else begin
            case (opcode_s)
              OP_MV: begin
                Rout = y_dec_s;
                Rin  = x_dec_s;
              end
              OP_MVI: begin
                DINout = 1'b1;
                Rin    = x_dec_s;
              end
              default: begin
                Rin = '0;
              end
            endcase
            Done         = 1'b1;
            state_next_s = T0;
          end
        end
        T2: begin
          Rout         = y_dec_s;
          Gin          = 1'b1;
          ALUop        = alu_code(opcode_s);
          state_next_s = T3;
        end
        T3: begin
          Gout         = 1'b1;
          Rin          = x_dec_s;
          Done         = 1'b1;
          state_next_s = T0;
        end
        default: begin
          state_next_s = T0;
        end
      endcase
    end
`ifndef PROC_CTRL_LOGIC_OPS_EN
    ALUop[1] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Scoreboard bench for proc_ctrl_fsm; expectations follow PROC_CTRL_LOGIC_OPS_EN.
module tb_proc_ctrl_fsm;

  logic       Clock;
  logic       Resetn;
  logic       Run;
  logic [8:0] IR;
  logic       IRin;
  logic [7:0] Rin;
  logic [7:0] Rout;
  logic       DINout;
  logic       Gout;
  logic       Ain;
  logic       Gin;
  logic [1:0] ALUop;
  logic       Done;
  logic [1:0] Tstep;

  int checks_r = 0;
  int errors_r = 0;

  typedef struct {
    string       tag;
    logic [25:0] v;
  } exp_t;

  exp_t sb_q[$];

  proc_ctrl_fsm #(.NREGS(8)) dut (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .IR(IR),
    .IRin(IRin), .Rin(Rin), .Rout(Rout), .DINout(DINout), .Gout(Gout),
    .Ain(Ain), .Gin(Gin), .ALUop(ALUop), .Done(Done), .Tstep(Tstep)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Fields: IRin Rin Rout DINout Gout Ain Gin ALUop Done Tstep
  function automatic logic [25:0] ex(input logic irin, input logic [7:0] rin,
      input logic [7:0] rout, input logic din, input logic gout, input logic ain,
      input logic gin, input logic [1:0] alu, input logic done, input logic [1:0] ts);
    return {irin, rin, rout, din, gout, ain, gin, alu, done, ts};
  endfunction

  task automatic check_eq(input string tag, input logic [25:0] got, input logic [25:0] exp);
    checks_r++;
    if (got !== exp) begin
      errors_r++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs, queue the expectation, compare at the falling edge
  task automatic step(input string tag, input logic rstn, input logic run,
                      input logic [8:0] ir, input logic [25:0] exp);
    exp_t e;
    Resetn = rstn;
    Run    = run;
    IR     = ir;
    e.tag  = tag;
    e.v    = exp;
    sb_q.push_back(e);
    @(negedge Clock);
    e = sb_q.pop_front();
    check_eq(e.tag, {IRin, Rin, Rout, DINout, Gout, Ain, Gin, ALUop, Done, Tstep}, e.v);
    @(posedge Clock);
    #1;
  endtask

  localparam logic [8:0] I_MV   = 9'b000_001_010;
  localparam logic [8:0] I_MVI  = 9'b001_011_000;
  localparam logic [8:0] I_SUB  = 9'b011_000_001;
  localparam logic [8:0] I_ADD  = 9'b010_010_101;
  localparam logic [8:0] I_AND  = 9'b100_010_011;
  localparam logic [8:0] I_OR   = 9'b101_001_000;
  localparam logic [8:0] I_UND  = 9'b110_001_001;

  logic [25:0] z;

  initial begin
    z = ex(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0);
    step("rst0",     1'b0, 1'b1, 9'd0, z);
    step("rst1",     1'b0, 1'b1, 9'd0, z);
    step("idle",     1'b1, 1'b0, 9'd0, z);

    step("mv_t0",    1'b1, 1'b1, I_MV,  ex(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0));
    step("mv_t1",    1'b1, 1'b0, I_MV,  ex(1'b0, 8'h02, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'd1));
    step("mv_back",  1'b1, 1'b0, I_MV,  z);

    step("mvi_t0",   1'b1, 1'b1, I_MVI, ex(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0));
    step("mvi_t1",   1'b1, 1'b0, I_MVI, ex(1'b0, 8'h08, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'd1));

    step("sub_t0",   1'b1, 1'b1, I_SUB, ex(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0));
    step("sub_t1",   1'b1, 1'b1, I_SUB, ex(1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'd1));
    step("sub_t2",   1'b1, 1'b1, I_SUB, ex(1'b0, 8'h00, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 2'd2));
    step("sub_t3",   1'b1, 1'b0, I_SUB, ex(1'b0, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 2'd3));
    step("sub_back", 1'b1, 1'b0, I_SUB, z);

    step("add_t0",   1'b1, 1'b1, I_ADD, ex(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0));
    step("add_t1",   1'b1, 1'b0, I_ADD, ex(1'b0, 8'h00, 8'h04, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'd1));
    step("add_rst",  1'b0, 1'b0, I_ADD, z);
    step("add_ab0",  1'b1, 1'b0, I_ADD, z);
    step("add_ab1",  1'b1, 1'b0, I_ADD, z);

    step("und_t0",   1'b1, 1'b1, I_UND, ex(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0));
    step("und_t1",   1'b1, 1'b0, I_UND, ex(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'd1));
    step("und_back", 1'b1, 1'b0, I_UND, z);

    step("and_t0",   1'b1, 1'b1, I_AND, ex(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0));
`ifdef PROC_CTRL_LOGIC_OPS_EN
    step("and_t1",   1'b1, 1'b1, I_AND, ex(1'b0, 8'h00, 8'h04, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'd1));
    step("and_t2",   1'b1, 1'b1, I_AND, ex(1'b0, 8'h00, 8'h08, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 2'd2));
    step("and_t3",   1'b1, 1'b1, I_AND, ex(1'b0, 8'h04, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 2'd3));
    step("or_t0",    1'b1, 1'b1, I_OR,  ex(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0));
    step("or_t1",    1'b1, 1'b0, I_OR,  ex(1'b0, 8'h00, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'd1));
    step("or_t2",    1'b1, 1'b0, I_OR,  ex(1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 2'd2));
    step("or_t3",    1'b1, 1'b0, I_OR,  ex(1'b0, 8'h02, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 2'd3));
`else
    step("and_t1",   1'b1, 1'b1, I_AND, ex(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'd1));
    step("and_b2b",  1'b1, 1'b1, I_OR,  ex(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0));
    step("or_t1",    1'b1, 1'b0, I_OR,  ex(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'd1));
`endif
    step("end_idle", 1'b1, 1'b0, 9'd0, z);

    if (sb_q.size() != 0) begin
      errors_r++;
      $display("FAIL scoreboard_drain got %0d expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
    $finish;
  end

endmodule
